// File: rtl/alu_md_unit.sv
// rtl/alu_md_unit.sv - EX-stage ALU with control decode and multi-cycle multiply/divide (HI/LO)
module alu_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       OP,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e             state, state_nx;
  op_e                op_sel;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   mag_b;
  // Upper half: partial product / partial remainder. Lower half: multiplier / dividend-quotient.
  logic [2*WIDTH-1:0] p;
  logic               op_div, neg_lo, neg_hi, bz;

  logic               accept, is_mul, is_div, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_bin;
  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ovf;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  assign accept    = valid_in & ready;
  assign is_mul    = (op_sel == OP_MULT) || (op_sel == OP_MULTU);
  assign is_div    = (op_sel == OP_DIV)  || (op_sel == OP_DIVU);
  assign is_signed = (op_sel == OP_MULT) || (op_sel == OP_DIV);
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_bin   = b_neg ? -b : b;
  assign sum       = a + b;
  assign diff      = a - b;

  // Map ALUOp/func/OP onto one internal operation; unknown encodings fall back to add
  always_comb begin
    op_sel = OP_ADD;
    case (ALUOp)
      2'b00: op_sel = OP_ADD;
      2'b01: op_sel = OP_SUB;
      2'b10: begin
        case (func)
          6'b100000: op_sel = OP_ADD;
          6'b100010: op_sel = OP_SUB;
          6'b100100: op_sel = OP_AND;
          6'b100101: op_sel = OP_OR;
          6'b100110: op_sel = OP_XOR;
          6'b100111: op_sel = OP_NOR;
          6'b101010: op_sel = OP_SLT;
          6'b011000: op_sel = OP_MULT;
          6'b011001: op_sel = OP_MULTU;
          6'b011010: op_sel = OP_DIV;
          6'b011011: op_sel = OP_DIVU;
          6'b010000: op_sel = OP_MFHI;
          6'b010010: op_sel = OP_MFLO;
          default:   op_sel = OP_ADD;
        endcase
      end
      default: begin
        case (OP)
          6'b001000: op_sel = OP_ADD;
          6'b001100: op_sel = OP_AND;
          6'b001101: op_sel = OP_OR;
          6'b001110: op_sel = OP_XOR;
          6'b001010: op_sel = OP_SLT;
          default:   op_sel = OP_ADD;
        endcase
      end
    endcase
  end

  // Single-cycle result and signed-overflow detection
  always_comb begin
    alu_res = sum;
    alu_ovf = 1'b0;
    case (op_sel)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = sum;
    endcase
  end

  // One shift-add or restoring-divide step per cycle, plus the sign fixup values
  always_comb begin
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{p[0]}} & mag_b};
    mul_next  = {mul_sum, p[WIDTH-1:1]};
    div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_b};
    div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    prod_fix  = neg_lo ? -p : p;
    quo_fix   = bz ? {WIDTH{1'b1}} : (neg_lo ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
    rem_fix   = neg_hi ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    fix_hi    = op_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo    = op_div ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state: iterate WIDTH cycles in MUL/DIV, then one fixup cycle
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul)      state_nx = S_MUL;
        else if (accept && is_div) state_nx = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == '0) state_nx = S_FIX;
      default:      state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready = (state == S_IDLE);
  end

  // Iteration datapath and HI/LO; HI/LO change only at mult/div completion or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      p      <= '0;
      mag_b  <= '0;
      op_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      bz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && (is_mul || is_div)) begin
            cnt    <= CW'(WIDTH-1);
            p      <= {{WIDTH{1'b0}}, mag_a};
            mag_b  <= mag_bin;
            op_div <= is_div;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            bz     <= (b == '0);
          end
        end
        S_MUL: begin
          p <= mul_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_DIV: begin
          p <= div_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
      endcase
    end
  end

  // Result/flag registers: written on single-cycle accept or at fixup exit, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      ovf       <= 1'b0;
      div0      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == S_FIX) begin
        out_valid <= 1'b1;
        result    <= fix_lo;
        zero      <= (fix_lo == '0);
        ovf       <= 1'b0;
        div0      <= op_div & bz;
      end else if (accept && !is_mul && !is_div) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        zero      <= (alu_res == '0);
        ovf       <= alu_ovf;
        div0      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_md_unit.sv
// tb/tb_alu_md_unit.sv - randomized and directed bench for alu_md_unit against a behavioural model
module tb_alu_md_unit;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SLT,
                K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO} kind_e;

  logic         clk = 1'b0;
  logic         rst, valid_in, ready, out_valid, zero, ovf, div0;
  logic [1:0]   ALUOp;
  logic [5:0]   OP, func;
  logic [W-1:0] a, b, result;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] m_hi, m_lo;

  logic [13:0] enc_tab [0:19] = '{
    {2'b00, 6'h00, 6'h00}, {2'b01, 6'h00, 6'h00},
    {2'b10, 6'h00, 6'h20}, {2'b10, 6'h00, 6'h22}, {2'b10, 6'h00, 6'h24},
    {2'b10, 6'h00, 6'h25}, {2'b10, 6'h00, 6'h26}, {2'b10, 6'h00, 6'h27},
    {2'b10, 6'h00, 6'h2a}, {2'b10, 6'h00, 6'h18}, {2'b10, 6'h00, 6'h19},
    {2'b10, 6'h00, 6'h1a}, {2'b10, 6'h00, 6'h1b}, {2'b10, 6'h00, 6'h10},
    {2'b10, 6'h00, 6'h12}, {2'b10, 6'h00, 6'h3f},
    {2'b11, 6'h08, 6'h00}, {2'b11, 6'h0c, 6'h00}, {2'b11, 6'h0a, 6'h00},
    {2'b11, 6'h3f, 6'h00}
  };

  always #5 clk = ~clk;

  alu_md_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready(ready),
    .ALUOp(ALUOp), .OP(OP), .func(func), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .zero(zero), .ovf(ovf), .div0(div0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic kind_e decode(input logic [1:0] aluop, input logic [5:0] op, input logic [5:0] fn);
    kind_e k;
    k = K_ADD;
    if (aluop == 2'b01) k = K_SUB;
    else if (aluop == 2'b10) begin
      case (fn)
        6'h22: k = K_SUB;   6'h24: k = K_AND;   6'h25: k = K_OR;
        6'h26: k = K_XOR;   6'h27: k = K_NOR;   6'h2a: k = K_SLT;
        6'h18: k = K_MULT;  6'h19: k = K_MULTU; 6'h1a: k = K_DIV;
        6'h1b: k = K_DIVU;  6'h10: k = K_MFHI;  6'h12: k = K_MFLO;
        default: k = K_ADD;
      endcase
    end else if (aluop == 2'b11) begin
      case (op)
        6'h0c: k = K_AND; 6'h0d: k = K_OR; 6'h0e: k = K_XOR; 6'h0a: k = K_SLT;
        default: k = K_ADD;
      endcase
    end
    return k;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] aluop, input logic [5:0] op,
                        input logic [5:0] fn, input logic [W-1:0] av, input logic [W-1:0] bv);
    kind_e        k;
    longint       sa, sb, s64, q, r;
    logic [63:0]  prod, ua, ub;
    logic [W-1:0] er, nhi, nlo;
    logic         eo, ed, multi, ready_bad;
    int           lat, wait_cnt;
    k   = decode(aluop, op, fn);
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    ua  = {32'b0, av};
    ub  = {32'b0, bv};
    eo  = 1'b0;
    ed  = 1'b0;
    nhi = m_hi;
    nlo = m_lo;
    er  = '0;
    multi = 1'b0;
    case (k)
      K_ADD: begin s64 = sa + sb; er = s64[31:0]; eo = (s64 > SMAX) || (s64 < SMIN); end
      K_SUB: begin s64 = sa - sb; er = s64[31:0]; eo = (s64 > SMAX) || (s64 < SMIN); end
      K_AND: er = av & bv;
      K_OR:  er = av | bv;
      K_XOR: er = av ^ bv;
      K_NOR: er = ~(av | bv);
      K_SLT: er = (sa < sb) ? 32'd1 : 32'd0;
      K_MFHI: er = m_hi;
      K_MFLO: er = m_lo;
      K_MULT: begin s64 = sa * sb; nhi = s64[63:32]; nlo = s64[31:0]; multi = 1'b1; end
      K_MULTU: begin prod = ua * ub; nhi = prod[63:32]; nlo = prod[31:0]; multi = 1'b1; end
      K_DIV: begin
        multi = 1'b1;
        if (bv == 0) begin nlo = '1; nhi = av; ed = 1'b1; end
        else begin q = sa / sb; r = sa % sb; nlo = q[31:0]; nhi = r[31:0]; end
      end
      default: begin
        multi = 1'b1;
        if (bv == 0) begin nlo = '1; nhi = av; ed = 1'b1; end
        else begin prod = ua / ub; nlo = prod[31:0]; prod = ua % ub; nhi = prod[31:0]; end
      end
    endcase
    if (multi) er = nlo;

    wait_cnt = 0;
    while (!ready && wait_cnt < 200) begin @(posedge clk); #1; wait_cnt++; end
    chk({tag, "_ready_in"}, 64'(ready), 64'(1'b1));

    ALUOp = aluop; OP = op; func = fn; a = av; b = bv; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;

    if (multi) begin
      chk({tag, "_busy"}, 64'(ready), 64'(1'b0));
      lat = 0;
      ready_bad = 1'b0;
      while (!out_valid && lat < 100) begin
        @(posedge clk); #1;
        lat++;
        if (!out_valid && ready) ready_bad = 1'b1;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(W + 1));
      chk({tag, "_ready_low"}, 64'(ready_bad), 64'(1'b0));
      chk({tag, "_ready_done"}, 64'(ready), 64'(1'b1));
      m_hi = nhi;
      m_lo = nlo;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_zero"}, 64'(zero), 64'(er == 0));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    chk({tag, "_div0"}, 64'(div0), 64'(ed));
  endtask

  initial begin
    logic [13:0]  e;
    logic [W-1:0] ra, rb;
    int           lat, pulses;
    rst = 1'b1; valid_in = 1'b0; ALUOp = 2'b00; OP = '0; func = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 64'(ready), 64'(1'b1));
    chk("rst_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_zero", 64'(zero), 64'(1'b1));
    chk("rst_ovf", 64'(ovf), 64'(1'b0));
    chk("rst_div0", 64'(div0), 64'(1'b0));

    run_op("add_ovf", 2'b10, 6'h00, 6'h20, 32'h7FFFFFFF, 32'h1);
    @(posedge clk); #1;
    chk("idle_valid", 64'(out_valid), 64'(1'b0));
    chk("idle_hold", 64'(result), 64'(32'h80000000));

    run_op("slti", 2'b11, 6'h0a, 6'h00, -32'sd5, 32'd3);
    run_op("sub_eq", 2'b01, 6'h00, 6'h00, 32'd9, 32'd9);

    run_op("mult", 2'b10, 6'h00, 6'h18, -32'sd3, 32'd7);
    run_op("mfhi_m", 2'b10, 6'h00, 6'h10, 32'd0, 32'd0);
    run_op("mflo_m", 2'b10, 6'h00, 6'h12, 32'd0, 32'd0);
    run_op("div", 2'b10, 6'h00, 6'h1a, -32'sd7, 32'd2);
    run_op("mfhi_d", 2'b10, 6'h00, 6'h10, 32'd0, 32'd0);
    run_op("mflo_d", 2'b10, 6'h00, 6'h12, 32'd0, 32'd0);
    run_op("divu0", 2'b10, 6'h00, 6'h1b, 32'd7, 32'd0);
    run_op("mfhi_z", 2'b10, 6'h00, 6'h10, 32'd0, 32'd0);
    run_op("mflo_z", 2'b10, 6'h00, 6'h12, 32'd0, 32'd0);

    // Divide with valid_in held high; the following add must wait for ready
    ALUOp = 2'b10; func = 6'h1a; a = 32'd100; b = 32'd7; valid_in = 1'b1;
    @(posedge clk); #1;
    ALUOp = 2'b00; a = 32'd5; b = 32'd6;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("busy_latency", 64'(lat), 64'(W + 1));
    chk("busy_divres", 64'(result), 64'(14));
    m_hi = 32'd2; m_lo = 32'd14;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("busy_add_valid", 64'(out_valid), 64'(1'b1));
    chk("busy_add_res", 64'(result), 64'(11));
    run_op("busy_mfhi", 2'b10, 6'h00, 6'h10, 32'd0, 32'd0);
    run_op("busy_mflo", 2'b10, 6'h00, 6'h12, 32'd0, 32'd0);

    // Reset ten cycles into a multu aborts it
    ALUOp = 2'b10; func = 6'h19; a = $urandom; b = $urandom | 32'h1; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort_ready", 64'(ready), 64'(1'b1));
    chk("abort_valid", 64'(out_valid), 64'(1'b0));
    chk("abort_zero", 64'(zero), 64'(1'b1));
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) pulses++; end
    chk("abort_no_pulse", 64'(pulses), 64'(0));
    run_op("abort_mfhi", 2'b10, 6'h00, 6'h10, 32'd0, 32'd0);
    run_op("abort_mflo", 2'b10, 6'h00, 6'h12, 32'd0, 32'd0);

    for (int i = 0; i < 60; i++) begin
      e  = enc_tab[$urandom_range(0, 19)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = ra;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), e[13:12], e[11:6], e[5:0], ra, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
